mult_div_unit: RTL
==================

Name: mult_div_unit

Overview:
- Multi-cycle multiply/divide unit in the E stage. Owns the HI and LO architectural registers.
- Acts as the responder to the main controller's `Start`/`XAluOp` control pair: executes mult, multu, div, divu, mthi and mtlo.
- Exposes `Busy` so the hazard unit can stall mfhi, mflo and any new mult/div instruction while an operation is in flight.

Parameters:
- MULT_CYCLES, 5, number of cycles Busy stays high for mult/multu.
- DIV_CYCLES, 10, number of cycles Busy stays high for div/divu.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- Start  input  2  0 = none; 1 = launch mult/div; 2 = move to HI/LO.
- XAluOp  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 reserved.
- A  input  32  forwarded rs value.
- B  input  32  forwarded rt value.
- Flush  input  1  exception/interrupt taken this cycle; suppresses any launch or move.
- Busy  output  1  operation in flight.
- HI  output  32  HI register.
- LO  output  32  LO register.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - HI=0, LO=0, Busy=0.
  - State IDLE, counter 0, pending result 0.
  - An in-flight operation is discarded.
- Accept condition: `acc = !Flush && !Busy`.
- States: IDLE, BUSY. Busy = (state==BUSY), driven directly from the register, no combinational path from inputs.
- IDLE, acc, Start==1, XAluOp 0..3:
  - On the clock edge, latch the 64-bit pending result {hi,lo} computed from A and B.
  - Set counter to MULT_CYCLES or DIV_CYCLES; go to BUSY.
- mult/multu: 64-bit product; signed (mult) or unsigned (multu). hi = upper 32 bits, lo = lower 32 bits.
- div/divu:
  - lo = quotient, hi = remainder. Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - B==0: pending result = current {HI,LO}, so HI/LO are left unchanged. Busy still asserts for the full DIV_CYCLES.
- BUSY, each edge: counter decrements. On the edge where counter==1:
  - HI/LO <= pending; state -> IDLE; Busy falls on that same edge.
  - Busy is therefore high for exactly N cycles, and an mfhi/mflo in the following cycle reads the new values.
- Start==2, acc, XAluOp 4: HI <= A on the edge. XAluOp 5: LO <= A on the edge. Busy stays 0, single cycle.
- Start!=0 while Busy: ignored. The hazard unit guarantees this never happens; the bench flags it as an assertion.
- Flush=1 with Start!=0 in the same cycle: no launch, no move; HI/LO and Busy unchanged.
- Flush while already BUSY: the operation continues and commits. It was issued by an instruction older than the victim.
- Start==0, or XAluOp 6/7 without the optional feature: no effect.
- Counter width: $clog2(max(MULT_CYCLES,DIV_CYCLES)+1).

Optional Feature:
- Macro: MULT_ACC_EN.
- Defined:
  - XAluOp 6 = madd: pending = {HI,LO} + signed(A*B), 64-bit, wrap-around.
  - XAluOp 7 = maddu: same with unsigned(A*B).
  - Both use MULT_CYCLES and the same Busy/commit rules.
- Undefined: codes 6/7 are ignored as no-ops. The controller never issues them.

Decomposition:
- Shared package/header (alongside the existing size macros):
  - XAluOp encodings (XOP_MULT..XOP_MTLO, XOP_MADD, XOP_MADDU).
  - Start encodings (START_NONE, START_MD, START_MOVE).
  - xaluop_size / start_size widths.
- One natural sub-module: md_datapath. Purely combinational; A, B, XAluOp, current {HI,LO} -> 64-bit pending result, including the divide-by-zero rule.
- The FSM, counter and HI/LO registers stay in mult_div_unit.

Test Plan:
1. mult A=0xFFFFFFFF, B=2 -> Busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE. multu with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
2. div A=0xFFFFFFF9 (-7), B=2 -> Busy high 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7, B=0 -> Busy 10 cycles, HI/LO unchanged.
3. mthi A=0x12345678, then mtlo A=0x9ABCDEF0 on the next cycle -> HI/LO update on each edge; Busy stays 0 throughout.
4. Start=1 mult together with Flush=1 -> Busy stays 0, HI/LO unchanged. Flush asserted in cycle 2 of a running div -> result still commits after 10 cycles.
5. reset_n pulsed low asynchronously (mid-clock) in cycle 3 of a mult -> Busy, HI and LO go to 0 immediately; no commit afterwards.
6. MULT_ACC_EN defined: HI:LO=0x0:0xFFFFFFFF, then maddu A=1, B=1 -> HI=0x00000001, LO=0x00000000 after 5 cycles. Undefined: the same stimulus leaves HI/LO unchanged and Busy=0.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// Shared encodings for the multiply/divide unit: XAluOp and Start codes,
// their widths, and the FSM state type.
package mult_div_unit_pkg;

  localparam int xaluop_size = 3;
  localparam int start_size  = 2;

  // XAluOp encodings
  localparam logic [xaluop_size-1:0] XOP_MULT  = 3'd0;
  localparam logic [xaluop_size-1:0] XOP_MULTU = 3'd1;
  localparam logic [xaluop_size-1:0] XOP_DIV   = 3'd2;
  localparam logic [xaluop_size-1:0] XOP_DIVU  = 3'd3;
  localparam logic [xaluop_size-1:0] XOP_MTHI  = 3'd4;
  localparam logic [xaluop_size-1:0] XOP_MTLO  = 3'd5;
  localparam logic [xaluop_size-1:0] XOP_MADD  = 3'd6;
  localparam logic [xaluop_size-1:0] XOP_MADDU = 3'd7;

  // Start encodings
  localparam logic [start_size-1:0] START_NONE = 2'd0;
  localparam logic [start_size-1:0] START_MD   = 2'd1;
  localparam logic [start_size-1:0] START_MOVE = 2'd2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_t;

endpackage

// File: rtl/mult_div_unit_md_datapath.sv
// md_datapath: combinational result generator for the mult/div unit.
// Produces the 64-bit {hi,lo} value that will be committed at the end of
// the operation. A zero divisor yields the current {HI,LO} so the commit
// leaves the registers untouched.
// Optional: MULT_ACC_EN adds madd/maddu (accumulate into {HI,LO}).
module md_datapath
  import mult_div_unit_pkg::*;
(
  input  logic [31:0]            a,
  input  logic [31:0]            b,
  input  logic [xaluop_size-1:0] xaluop,
  input  logic [63:0]            hilo,
  output logic [63:0]            pending
);

  logic [63:0] prod_signed_s;
  logic [63:0] prod_unsigned_s;
  logic [31:0] mag_a_s;
  logic [31:0] mag_b_s;
  logic [31:0] qmag_s;
  logic [31:0] rmag_s;
  logic [31:0] squot_s;
  logic [31:0] srem_s;
  logic [31:0] uquot_s;
  logic [31:0] urem_s;

  // Products and quotients; signed divide works on magnitudes so that
  // 0x80000000 / -1 needs no special handling.
  always_comb begin
    prod_signed_s   = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    prod_unsigned_s = {32'd0, a} * {32'd0, b};
    mag_a_s         = a[31] ? (32'd0 - a) : a;
    mag_b_s         = b[31] ? (32'd0 - b) : b;
    if (b == 32'd0) begin
      qmag_s  = 32'd0;
      rmag_s  = 32'd0;
      uquot_s = 32'd0;
      urem_s  = 32'd0;
    end else begin
      qmag_s  = mag_a_s / mag_b_s;
      rmag_s  = mag_a_s % mag_b_s;
      uquot_s = a / b;
      urem_s  = a % b;
    end
    // Quotient truncates toward zero, remainder follows the dividend sign.
    squot_s = (a[31] ^ b[31]) ? (32'd0 - qmag_s) : qmag_s;
    srem_s  = a[31] ? (32'd0 - rmag_s) : rmag_s;
  end

  // Select the pending {hi,lo} for the requested operation.
  always_comb begin
    pending = hilo;
    case (xaluop)
      XOP_MULT:  pending = prod_signed_s;
      XOP_MULTU: pending = prod_unsigned_s;
      XOP_DIV: begin
        if (b == 32'd0) begin
          pending = hilo;
        end else begin
          pending = {srem_s, squot_s};
        end
      end
      XOP_DIVU: begin
        if (b == 32'd0) begin
          pending = hilo;
        end else begin
          pending = {urem_s, uquot_s};
        end
      end
`ifdef MULT_ACC_EN
      XOP_MADD:  pending = hilo + prod_signed_s;
      XOP_MADDU: pending = hilo + prod_unsigned_s;
`endif
      default:   pending = hilo;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle multiply/divide unit owning HI and LO.
// A launch latches the result at issue time and holds Busy for a fixed
// number of cycles, committing {HI,LO} on the edge where Busy falls.
// mthi/mtlo write HI/LO in a single cycle. Flush suppresses new launches
// and moves but never cancels an operation already in flight.
// Optional: MULT_ACC_EN enables madd/maddu (XAluOp 6/7).
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [start_size-1:0]  Start,
  input  logic [xaluop_size-1:0] XAluOp,
  input  logic [31:0]            A,
  input  logic [31:0]            B,
  input  logic                   Flush,
  output logic                   Busy,
  output logic [31:0]            HI,
  output logic [31:0]            LO
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  md_state_t   state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [63:0] pending_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;
  logic        busy_r;

  logic        acc_s;
  logic        launch_s;
  logic        move_hi_s;
  logic        move_lo_s;
  logic [CNT_W-1:0] cycles_s;
  logic [63:0] pending_s;

  md_datapath u_datapath (
    .a       (A),
    .b       (B),
    .xaluop  (XAluOp),
    .hilo    ({hi_r, lo_r}),
    .pending (pending_s)
  );

  // Decode which request, if any, is accepted this cycle.
  always_comb begin
    acc_s     = !Flush && (state_r == ST_IDLE);
    launch_s  = 1'b0;
    move_hi_s = 1'b0;
    move_lo_s = 1'b0;
    cycles_s  = CNT_W'(MULT_CYCLES);
    if (acc_s && (Start == START_MD)) begin
      case (XAluOp)
        XOP_MULT, XOP_MULTU: launch_s = 1'b1;
        XOP_DIV, XOP_DIVU: begin
          launch_s = 1'b1;
          cycles_s = CNT_W'(DIV_CYCLES);
        end
`ifdef MULT_ACC_EN
        XOP_MADD, XOP_MADDU: launch_s = 1'b1;
`endif
        default: launch_s = 1'b0;
      endcase
    end else if (acc_s && (Start == START_MOVE)) begin
      case (XAluOp)
        XOP_MTHI: move_hi_s = 1'b1;
        XOP_MTLO: move_lo_s = 1'b1;
        default: begin
          move_hi_s = 1'b0;
          move_lo_s = 1'b0;
        end
      endcase
    end else begin
      launch_s = 1'b0;
    end
  end

  // FSM, countdown and HI/LO registers; commit on the last busy edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= '0;
      pending_r <= 64'd0;
      hi_r      <= 32'd0;
      lo_r      <= 32'd0;
      busy_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (launch_s) begin
            pending_r <= pending_s;
            cnt_r     <= cycles_s;
            state_r   <= ST_BUSY;
            busy_r    <= 1'b1;
          end else if (move_hi_s) begin
            hi_r <= A;
          end else if (move_lo_s) begin
            lo_r <= A;
          end
        end
        ST_BUSY: begin
          if (cnt_r == CNT_W'(1)) begin
            hi_r    <= pending_r[63:32];
            lo_r    <= pending_r[31:0];
            cnt_r   <= '0;
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= '0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign Busy = busy_r;
  assign HI   = hi_r;
  assign LO   = lo_r;

endmodule
